// File: rtl/riscv_mmio_uart_tx_pkg.sv
// Shared definitions for the MMIO UART transmitter: register offsets,
// STATUS bit positions and TX state encodings.
package riscv_mmio_uart_tx_pkg;

  typedef enum logic [1:0] {
    UART_S_IDLE  = 2'd0,
    UART_S_START = 2'd1,
    UART_S_DATA  = 2'd2,
    UART_S_STOP  = 2'd3
  } uart_state_t;

  localparam logic [1:0] UART_OFS_TXDATA = 2'd0;
  localparam logic [1:0] UART_OFS_STATUS = 2'd1;
  localparam logic [1:0] UART_OFS_DIV    = 2'd2;

  localparam int UART_ST_FULL    = 0;
  localparam int UART_ST_EMPTY   = 1;
  localparam int UART_ST_BUSY    = 2;
  localparam int UART_ST_OVF     = 3;
  localparam int UART_ST_CNT_LSB = 4;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Single-clock FIFO with combinational head read; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module riscv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/riscv_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus: TXDATA, STATUS
// and DIV registers in a 16-byte window, FIFO-buffered serialisation.
module riscv_mmio_uart_tx
  import riscv_mmio_uart_tx_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] BASE_ADDR  = 32'h0000_1000,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [15:0]     DIV_RESET  = 16'd868
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_dmem_addr,
  input  logic            i_dmem_wr_en,
  input  logic [3:0]      i_dmem_byte_sel,
  input  logic [XLEN-1:0] i_dmem_wr_data,
  output logic [XLEN-1:0] o_dmem_rd_data,
  output logic            o_dmem_hit,
  output logic            o_uart_tx,
  output logic            o_uart_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_state_t  state, state_next;
  logic [15:0]  div, div_wr, frame_div, cnt;
  logic [2:0]   bit_idx;
  logic [7:0]   shift, fifo_data;
  logic         overflow, full, empty, push, pop, wr, bit_end, tx_d;
  logic [CW-1:0]   count;
  logic [1:0]      sel;
  logic [XLEN-1:0] status;
  logic            unused_bits;

  assign o_dmem_hit = (i_dmem_addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
  assign sel        = i_dmem_addr[3:2];
  assign wr         = o_dmem_hit && i_dmem_wr_en;
  assign push       = wr && (sel == UART_OFS_TXDATA) && i_dmem_byte_sel[0];
  assign unused_bits = ^{i_dmem_addr[1:0], i_dmem_wr_data[XLEN-1:16], i_dmem_byte_sel[3:2]};

  riscv_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data (i_dmem_wr_data[7:0]),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    status = '0;
    status[UART_ST_FULL]          = full;
    status[UART_ST_EMPTY]         = empty;
    status[UART_ST_BUSY]          = o_uart_busy;
    status[UART_ST_OVF]           = overflow;
    status[UART_ST_CNT_LSB +: 4]  = 4'(count);
  end

  always_comb begin
    o_dmem_rd_data = '0;
    if (o_dmem_hit) begin
      case (sel)
        UART_OFS_STATUS: o_dmem_rd_data = status;
        UART_OFS_DIV:    o_dmem_rd_data = XLEN'(div);
        default:         o_dmem_rd_data = '0;
      endcase
    end
  end

  assign div_wr[7:0]  = i_dmem_byte_sel[0] ? i_dmem_wr_data[7:0]  : div[7:0];
  assign div_wr[15:8] = i_dmem_byte_sel[1] ? i_dmem_wr_data[15:8] : div[15:8];

  // Overflow set takes priority over a clear landing in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div      <= DIV_RESET;
      overflow <= 1'b0;
    end else begin
      if (wr && (sel == UART_OFS_DIV) && |i_dmem_byte_sel[1:0])
        div <= (div_wr == 16'd0) ? 16'd1 : div_wr;
      if (push && full && !pop)
        overflow <= 1'b1;
      else if (wr && (sel == UART_OFS_STATUS) && i_dmem_byte_sel[0] && i_dmem_wr_data[UART_ST_OVF])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= UART_S_IDLE;
      o_uart_tx   <= 1'b1;
      o_uart_busy <= 1'b0;
    end else begin
      state       <= state_next;
      o_uart_tx   <= tx_d;
      o_uart_busy <= (state_next != UART_S_IDLE) || !empty;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      UART_S_IDLE:  if (!empty) state_next = UART_S_START;
      UART_S_START: if (bit_end) state_next = UART_S_DATA;
      UART_S_DATA:  if (bit_end && bit_idx == 3'd7) state_next = UART_S_STOP;
      UART_S_STOP:  if (bit_end) state_next = empty ? UART_S_IDLE : UART_S_START;
      default:      state_next = UART_S_IDLE;
    endcase
  end

  always_comb begin
    bit_end = (state != UART_S_IDLE) && (cnt == 16'd0);
    pop     = !empty && ((state == UART_S_IDLE) || (state == UART_S_STOP && bit_end));
    case (state)
      UART_S_START: tx_d = 1'b0;
      UART_S_DATA:  tx_d = shift[0];
      default:      tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_div <= '0;
    end else if (pop) begin
      shift     <= fifo_data;
      frame_div <= div;
      cnt       <= div - 16'd1;
      bit_idx   <= '0;
    end else if (state != UART_S_IDLE) begin
      if (bit_end) begin
        cnt <= frame_div - 16'd1;
        if (state == UART_S_DATA) begin
          shift   <= {1'b0, shift[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        cnt <= cnt - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mmio_uart_tx.sv
// Directed bench for riscv_mmio_uart_tx: register access, frame timing,
// back-to-back frames, overflow, divisor edges, decode and reset abort.
module tb_riscv_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_DV = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        wr_en;
  logic [3:0]  byte_sel;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        hit;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_mmio_uart_tx #(
    .XLEN(32), .BASE_ADDR(BASE), .FIFO_DEPTH(4), .DIV_RESET(16'd868)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_dmem_addr     (addr),
    .i_dmem_wr_en    (wr_en),
    .i_dmem_byte_sel (byte_sel),
    .i_dmem_wr_data  (wr_data),
    .o_dmem_rd_data  (rd_data),
    .o_dmem_hit      (hit),
    .o_uart_tx       (tx),
    .o_uart_busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; wr_data = d; byte_sel = be; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; wr_en = 1'b0;
    #1;
    d = rd_data;
  endtask

  task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    check(tag, d, exp);
  endtask

  // Samples the line once per cycle over a full frame, starting with the
  // start-bit cycle that appears on the next rising edge.
  task automatic check_frame(input string tag, input logic [7:0] b, input int div);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < div; c++) begin
        @(posedge clk); #1;
        check($sformatf("%s_bit%0d_c%0d", tag, i, c), {31'b0, tx}, {31'b0, bits[i]});
      end
    end
  endtask

  initial begin
    rst = 1'b1; addr = '0; wr_en = 1'b0; byte_sel = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check_rd("rst_status", A_ST, 32'h02);
    check_rd("rst_div", A_DV, 32'd868);
    check_rd("txdata_reads0", A_TX, 32'd0);

    // Single byte, DIV=4
    bus_wr(A_DV, 32'd4, 4'b0011);
    check_rd("div4", A_DV, 32'd4);
    bus_wr(A_TX, 32'h55, 4'b0001);
    check_rd("st_after_push", A_ST, 32'h10);
    @(posedge clk); #1;
    check("e1_tx_high", {31'b0, tx}, 32'd1);
    check("e1_busy", {31'b0, busy}, 32'd1);
    check_rd("st_after_pop", A_ST, 32'h06);
    check_frame("f55", 8'h55, 4);
    check("f55_busy_fall", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    check("f55_idle_tx", {31'b0, tx}, 32'd1);

    // Back-to-back frames
    bus_wr(A_TX, 32'h41, 4'b0001);
    bus_wr(A_TX, 32'h42, 4'b0001);
    check("b2b_busy", {31'b0, busy}, 32'd1);
    check_frame("f41", 8'h41, 4);
    check("b2b_busy_mid", {31'b0, busy}, 32'd1);
    check_frame("f42", 8'h42, 4);
    check("b2b_busy_fall", {31'b0, busy}, 32'd0);

    // DIV=0 stored as 1, 10-cycle frame
    bus_wr(A_DV, 32'd0, 4'b0011);
    check_rd("div0_as1", A_DV, 32'd1);
    bus_wr(A_TX, 32'hC3, 4'b0001);
    @(posedge clk); #1;
    check_frame("fc3", 8'hC3, 1);
    check("fc3_busy_fall", {31'b0, busy}, 32'd0);

    // Per-byte DIV write, then DIV change mid-frame
    bus_wr(A_DV, 32'h0000_AB02, 4'b0001);
    check_rd("div_lane0", A_DV, 32'd2);
    bus_wr(A_TX, 32'hA5, 4'b0001);
    bus_wr(A_TX, 32'h3C, 4'b0001);
    fork
      begin
        check_frame("fa5", 8'hA5, 2);
        check_frame("f3c", 8'h3C, 8);
      end
      begin
        repeat (3) @(posedge clk);
        #2 bus_wr(A_DV, 32'd8, 4'b0011);
      end
    join
    check("f3c_busy_fall", {31'b0, busy}, 32'd0);
    check_rd("div8", A_DV, 32'd8);

    // Overflow
    bus_wr(A_DV, 32'd1000, 4'b0011);
    for (int i = 0; i < 6; i++) bus_wr(A_TX, 32'h30 + i, 4'b0001);
    check_rd("ovf_status", A_ST, 32'h4D);
    bus_wr(A_ST, 32'h08, 4'b0001);
    check_rd("ovf_cleared", A_ST, 32'h45);
    bus_wr(A_ST, 32'h00, 4'b0001);
    check_rd("ovf_noclear_count", A_ST, 32'h45);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_rd("rst2_status", A_ST, 32'h02);
    check_rd("rst2_div", A_DV, 32'd868);

    // Decode
    addr = BASE + 32'h10; wr_data = 32'h77; byte_sel = 4'b0001; wr_en = 1'b1;
    #1;
    check("oow_hit", {31'b0, hit}, 32'd0);
    check("oow_rd", rd_data, 32'd0);
    @(posedge clk); #1;
    wr_en = 1'b0;
    check_rd("oow_nopush", A_ST, 32'h02);
    check_rd("st_lowbits_ignored", BASE + 32'h7, 32'h02);
    check_rd("reserved_reads0", BASE + 32'hC, 32'd0);
    bus_wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'b1111);
    check_rd("reserved_wr_ignored", A_DV, 32'd868);
    #1;
    check("in_window_hit", {31'b0, hit}, 32'd1);

    // Reset during a DATA bit
    bus_wr(A_DV, 32'd4, 4'b0011);
    bus_wr(A_TX, 32'h55, 4'b0001);
    bus_wr(A_TX, 32'h66, 4'b0001);
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_data0", {31'b0, tx}, 32'd0);
    check_rd("pre_rst_count", A_ST, 32'h14);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_tx", {31'b0, tx}, 32'd1);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check_rd("rst_mid_status", A_ST, 32'h02);
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_stays_high", {31'b0, tx}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_mmio_uart_tx.md
# riscv_mmio_uart_tx

Memory-mapped UART transmitter that sits on the RV32I core's data-memory bus as a responder beside `riscv_dmem`. It decodes CPU loads and stores aimed at its 16-byte window and buffers store bytes in a small FIFO. It serialises them as 8N1 frames on `o_uart_tx` and reports status back over the bus read-data path. It is the program-visible console for `riscvtest`-style programs and lets benches check output text instead of inspecting register dumps.

## Interface
- `XLEN`, 32, bus address/data width.
- `BASE_ADDR`, 32'h0000_1000, window base; must be 16-byte aligned.
- `FIFO_DEPTH`, 4, TX FIFO entries; power of two, ≥2.
- `DIV_RESET`, 16'd868, reset baud divisor in clocks per bit (100 MHz / 115200).

Ports:
- `i_clk` in 1: single clock, rising edge.
- `i_rst` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `i_dmem_addr` in XLEN: byte address from the core.
- `i_dmem_wr_en` in 1: store strobe. The write commits on the rising edge.
- `i_dmem_byte_sel` in 4: byte-lane enables.
- `i_dmem_wr_data` in XLEN: store data.
- `o_dmem_rd_data` out XLEN: combinational read data. It is 0 when `o_dmem_hit`=0.
- `o_dmem_hit` out 1: combinational. High when `i_dmem_addr[XLEN-1:4]==BASE_ADDR[XLEN-1:4]`.
- `o_uart_tx` out 1: registered serial line, idles high.
- `o_uart_busy` out 1: registered. High while a frame is in progress or the FIFO is non-empty.

## Operation
Register map by `addr[3:2]`:
- **0 TXDATA** (write-only, reads 0)
  - A write with `byte_sel[0]=1` pushes `wr_data[7:0]`.
- **1 STATUS**
  - Read layout: `[0]` full, `[1]` empty, `[2]` busy, `[3]` overflow (sticky), `[7:4]` FIFO count; all other bits 0.
  - Writing 1 to bit 3 with `byte_sel[0]=1` clears overflow.
- **2 DIV**
  - `[15:0]` is the divisor. Writes honour `byte_sel[1:0]` per byte.
  - A written value of 0 is stored as 1.
- **3**: reserved, reads 0, writes ignored.

Write rules:
- Writes take effect only when hit=1 and `wr_en`=1.
- `addr[1:0]` is ignored.

FIFO push rules:
- Full and no pop in the same cycle: the push is dropped and overflow is set.
- Full with a pop in the same cycle: the push is accepted and the count is unchanged.

TX state machine:
- **IDLE**
  - `o_uart_tx`=1.
  - If the FIFO is non-empty: pop the byte into the shift register, latch DIV into the frame divisor, load the baud counter with divisor−1, and go to START.
- **START**
  - `o_uart_tx`=0 for `div` cycles, then go to DATA with bit index 0.
- **DATA**
  - Send `shift[0]` for `div` cycles, then shift right. The frame is LSB first.
  - After bit index 7, go to STOP.
- **STOP**
  - `o_uart_tx`=1 for `div` cycles.
  - On the last cycle, if the FIFO is non-empty, pop and go straight to START with no idle gap. Otherwise go to IDLE.

Arithmetic:
- The baud counter is 16-bit and counts down; a bit ends when the counter is 0.
- The bit index is 3-bit.
- FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo depth. The count is one bit wider.

DIV written mid-frame takes effect only at the next frame start.

## Timing
- Reset values: `o_uart_tx`=1, `o_uart_busy`=0, FIFO empty (count 0), overflow 0, DIV=`DIV_RESET`, state IDLE, counters 0.
- Reset asserted mid-frame aborts the frame. The line is high from the next edge.
- Store at edge E:
  - the FIFO count is visible in STATUS reads from cycle E+1;
  - with the FIFO empty and the machine in IDLE, the pop occurs at edge E+1;
  - `o_uart_tx` falls at E+2.
- Frame length is exactly `10·div` cycles. The back-to-back frame period is also `10·div`.
- `o_uart_busy` rises at E+1 after the first push. It falls on the edge that enters IDLE with the FIFO empty.
- Reads have zero latency, which the single-cycle core requires. STATUS reflects registered state only.

## Structure
- Add `define`s to `riscv_configs.v`:
  - `UART_OFS_TXDATA`=0, `UART_OFS_STATUS`=1, `UART_OFS_DIV`=2;
  - STATUS bit positions;
  - FSM state encodings `UART_S_IDLE`/`START`/`DATA`/`STOP` (2-bit).
- One sub-module, `riscv_sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count). It is reusable for a future RX block.
- The top is integrated in `riscv_top` via address decode: read data is muxed between dmem and `o_dmem_rd_data` using `o_dmem_hit`, and dmem `wr_en` is gated by `!hit`.

## Test plan
- **Reset:** hold `i_rst` 2 cycles → `o_uart_tx`=1, STATUS=0x02, DIV reads 868.
- **Single byte:** set DIV=4, then store 0x55 to TXDATA at edge E.
  - `o_uart_tx` goes low at E+2 for 4 cycles.
  - Then the bits 1,0,1,0,1,0,1,0 follow, 4 cycles each, then high.
  - busy falls 40 cycles after E+1.
- **Back-to-back frames:** DIV=4, store 0x41 then 0x42 on consecutive cycles.
  - The second start bit begins exactly 40 cycles after the first.
  - There are no idle cycles between frames.
- **Overflow:** DIV=1000, store 6 bytes on consecutive edges.
  - First push popped at the next edge, so pushes 2–5 fill the FIFO (count 4) and push 6 is dropped; overflow=1.
  - Writing 0x08 to STATUS clears overflow while count stays 4.
- **Divisor edges:** write DIV=0 → reads 1, frame is 10 cycles.
  - Write DIV=8 mid-frame → the current frame keeps the old divisor and the next frame uses 8.
- **Decode and reset:**
  - A store to `BASE_ADDR+0x10` leaves hit=0 and no push.
  - Asserting `i_rst` during a DATA bit drives `o_uart_tx`=1 on the next edge and clears the FIFO to count 0.
